// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit_if
//  Description : Word-addressed memory bus between the load/store unit and
//                memory. The master issues a held request (bus_re / bus_we)
//                with a word address, byte enables and lane-replicated write
//                data. The slave answers with a single-cycle bus_ack, plus
//                bus_rdata for reads.
//  Ports       : bus_addr[31:0], bus_wdata[31:0], bus_sel[3:0], bus_re,
//                bus_we (master -> slave); bus_rdata[31:0], bus_ack
//                (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_unit_if;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_re;
  logic        bus_we;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_addr, bus_wdata, bus_sel, bus_re, bus_we,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_sel, bus_re, bus_we,
    output bus_rdata, bus_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_unit
//  Description : Load/store unit. It accepts a load or store from the
//                datapath and stalls the pipeline until the access finishes.
//                It runs one bus transfer. For loads it aligns the read data
//                and then sign- or zero-extends it. It sends a one-cycle
//                done pulse, and err goes high with done on an illegal
//                request or a bus timeout.
//  Ports       : clk, rst (async, active-high)
//                alu_result[31:0], store_data[31:0], mem_read, mem_write,
//                funct3[2:0]                    - request from datapath
//                stall, load_data[31:0], done, err - status to datapath
//                bus (mem_access_unit_if.master) - memory bus
//  Parameters  : TIMEOUT_CYC - number of ACCESS cycles to wait for bus_ack;
//                0 disables the timeout
//  Macros      : MISALIGN_TRAP_EN - when defined, a misaligned halfword or
//                word access is rejected with err and no bus cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT_CYC = 64
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic [31:0] alu_result,
  input  wire logic [31:0] store_data,
  input  wire logic        mem_read,
  input  wire logic        mem_write,
  input  wire logic [2:0]  funct3,
  output logic             stall,
  output logic [31:0]      load_data,
  output logic             done,
  output logic             err,
  mem_access_unit_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam int              CNT_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam bit              C_TO_EN    = (TIMEOUT_CYC > 0);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic [2:0]       r_funct3;
  logic             r_write;
  logic             r_err;
  logic [31:0]      r_load;
  logic [CNT_W-1:0] r_cnt;

  logic             w_req;
  logic             w_illegal;
  logic             w_misalign;
  logic             w_timeout;
  logic [31:0]      w_shift;
  logic [31:0]      w_ext;

  assign w_req = mem_read | mem_write;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((funct3[1:0] == 2'b01) & alu_result[0]) |
                      ((funct3[1:0] == 2'b10) & (|alu_result[1:0]));
`else
  assign w_misalign = 1'b0;
`endif

  // Reject a request when it is both a load and a store, when funct3 is
  // undefined, or when it is an unsigned store.
  always_comb begin
    w_illegal = (mem_read & mem_write) | w_misalign;
    case (funct3)
      3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
      3'b100, 3'b101:         w_illegal = w_illegal | mem_write;
      default:                ;
    endcase
  end

  // The timeout fires in the last cycle that still allows an ack. An ack in
  // that same cycle wins over the timeout.
  assign w_timeout = C_TO_EN && (r_cnt == C_CNT_LAST) && !bus.bus_ack;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req) w_next = w_illegal ? S_DONE : S_ACCESS;
      S_ACCESS: if (bus.bus_ack || w_timeout) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output logic. The bus strobes come only from the state and the latched
  // request, so reset removes them at once without waiting for a clock.
  always_comb begin
    stall         = ((r_state == S_IDLE) && w_req) || (r_state == S_ACCESS);
    done          = (r_state == S_DONE);
    err           = (r_state == S_DONE) && r_err;
    load_data     = r_load;
    bus.bus_addr  = {r_addr[31:2], 2'b00};
    bus.bus_re    = (r_state == S_ACCESS) && !r_write;
    bus.bus_we    = (r_state == S_ACCESS) && r_write;
    bus.bus_sel   = 4'b0000;
    bus.bus_wdata = 32'h0;
    if (r_state == S_ACCESS) begin
      case (r_funct3[1:0])
        2'b00: begin
          bus.bus_sel   = 4'b0001 << r_addr[1:0];
          bus.bus_wdata = {4{r_data[7:0]}};
        end
        2'b01: begin
          bus.bus_sel   = 4'b0011 << {r_addr[1], 1'b0};
          bus.bus_wdata = {2{r_data[15:0]}};
        end
        default: begin
          bus.bus_sel   = 4'b1111;
          bus.bus_wdata = r_data;
        end
      endcase
    end
  end

  // Move the addressed lane down to bit 0, then extend it to 32 bits.
  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_shift = bus.bus_rdata >> {r_addr[1:0], 3'b000};
      2'b01:   w_shift = bus.bus_rdata >> {r_addr[1], 4'b0000};
      default: w_shift = bus.bus_rdata;
    endcase
    case (r_funct3)
      3'b000:  w_ext = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b001:  w_ext = {{16{w_shift[15]}}, w_shift[15:0]};
      3'b100:  w_ext = {24'h0, w_shift[7:0]};
      3'b101:  w_ext = {16'h0, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
  end

  // Request latch, timeout counter and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= 32'h0;
      r_data   <= 32'h0;
      r_funct3 <= 3'b000;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_load   <= 32'h0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_req) begin
            r_addr   <= alu_result;
            r_data   <= store_data;
            r_funct3 <= funct3;
            r_write  <= mem_write;
            r_err    <= w_illegal;
            if (w_illegal) r_load <= 32'h0;
          end
        end
        S_ACCESS: begin
          if (C_TO_EN) r_cnt <= r_cnt + 1'b1;
          if (bus.bus_ack) begin
            if (!r_write) r_load <= w_ext;
          end else if (w_timeout) begin
            r_err  <= 1'b1;
            r_load <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_unit
//  Description : Self-checking bench for mem_access_unit with TIMEOUT_CYC=4.
//                It runs directed scenarios and then random transfers. The
//                expected results come from a lane/byte reference model.
//                Honours MISALIGN_TRAP_EN in the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_result, store_data, load_data;
  logic        mem_read, mem_write, stall, done, err;
  logic [2:0]  funct3;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_ld;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_result (alu_result),
    .store_data (store_data),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .stall      (stall),
    .load_data  (load_data),
    .done       (done),
    .err        (err),
    .bus        (bus_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // ---- reference model -----------------------------------------------------
  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  // Lowest byte lane used by the access.
  function automatic int first_lane(input logic [2:0] f3, input logic [31:0] a);
    int s = size_of(f3);
    if (s == 1) return int'(a[1:0]);
    if (s == 2) return a[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic bit is_illegal(input bit rd, input bit wr, input logic [2:0] f3,
                                    input logic [31:0] a);
    bit ill = (rd && wr) || (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
              (wr && (f3 == 3'd4 || f3 == 3'd5));
`ifdef MISALIGN_TRAP_EN
    if (size_of(f3) == 2 && a[0]) ill = 1'b1;
    if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) ill = 1'b1;
`endif
    return ill;
  endfunction

  function automatic logic [3:0] model_sel(input logic [2:0] f3, input logic [31:0] a);
    logic [3:0] s = 4'b0000;
    int lo = first_lane(f3, a);
    for (int i = 0; i < 4; i++)
      if (i >= lo && i < lo + size_of(f3)) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    int s = size_of(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % s) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] v = 32'h0;
    int s  = size_of(f3);
    int lo = first_lane(f3, a);
    for (int k = 0; k < s; k++) v[8*k +: 8] = rd[8*(lo+k) +: 8];
    if (!f3[2] && s < 4 && v[8*s-1]) v = v | (32'hFFFF_FFFF << (8*s));
    return v;
  endfunction

  // ---- one transfer, entered and left on a negedge with the unit idle ------
  // ack_at: the ACCESS cycle index that gets the ack; TO or more = no ack.
  task automatic txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] sd, input int ack_at, input logic [31:0] rdata);
    bit ill = is_illegal(rd, wr, f3, a);
    bit timed_out = 1'b1;
    mem_read = rd; mem_write = wr; funct3 = f3; alu_result = a; store_data = sd;
    #1;
    check("stall_on_request", stall, 1'b1);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0; alu_result = $urandom; store_data = $urandom;
    if (ill) begin
      check("illegal_no_re", bus_if.bus_re, 1'b0);
      check("illegal_no_we", bus_if.bus_we, 1'b0);
      check("illegal_done", done, 1'b1);
      check("illegal_err", err, 1'b1);
      exp_ld = 32'h0;
    end else begin
      bus_if.bus_rdata = $urandom;
      for (int i = 0; i < TO; i++) begin
        check("access_re", bus_if.bus_re, rd);
        check("access_we", bus_if.bus_we, wr);
        check("access_addr", bus_if.bus_addr, {a[31:2], 2'b00});
        check("access_sel", bus_if.bus_sel, model_sel(f3, a));
        if (wr) check("access_wdata", bus_if.bus_wdata, model_wdata(f3, sd));
        check("access_stall", stall, 1'b1);
        check("access_no_done", done, 1'b0);
        if (i == ack_at) begin
          bus_if.bus_ack = 1'b1; bus_if.bus_rdata = rdata; timed_out = 1'b0;
        end
        @(negedge clk);
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = $urandom;
        if (!timed_out) break;
      end
      check("done_pulse", done, 1'b1);
      check("done_err", err, timed_out);
      check("done_re_low", bus_if.bus_re, 1'b0);
      check("done_we_low", bus_if.bus_we, 1'b0);
      if (timed_out) exp_ld = 32'h0;
      else if (rd) exp_ld = model_load(f3, a, rdata);
    end
    check("done_stall_low", stall, 1'b0);
    check("done_load_data", load_data, exp_ld);
    @(negedge clk);
    check("done_single_cycle", done, 1'b0);
    check("idle_load_hold", load_data, exp_ld);
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    alu_result = 32'h0; store_data = 32'h0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'h0;
    exp_ld = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_stall", stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_load", load_data, 32'h0);
    check("rst_re", bus_if.bus_re, 1'b0);
    check("rst_we", bus_if.bus_we, 1'b0);
    check("rst_addr", bus_if.bus_addr, 32'h0);
    check("rst_sel", bus_if.bus_sel, 4'h0);
    check("rst_wdata", bus_if.bus_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // LW with an immediate ack: done three cycles after the request
    txn(1, 0, 3'b010, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
    check("lw_value", load_data, 32'hDEAD_BEEF);
    // LB / LBU of the top byte lane
    txn(1, 0, 3'b000, 32'h0000_0103, 32'h0, 1, 32'h8011_2233);
    check("lb_value", load_data, 32'hFFFF_FF80);
    txn(1, 0, 3'b100, 32'h0000_0103, 32'h0, 0, 32'h8011_2233);
    check("lbu_value", load_data, 32'h0000_0080);
    // SH to the upper half with the ack late; load_data must not change
    txn(0, 1, 3'b001, 32'h0000_0202, 32'h0000_ABCD, 2, 32'h1234_5678);
    check("sh_keeps_load", load_data, 32'h0000_0080);
    // LW with no ack: the unit times out
    txn(1, 0, 3'b010, 32'h0000_0300, 32'h0, 99, 32'h0);
    // Misaligned LW
    txn(1, 0, 3'b010, 32'h0000_0101, 32'h0, 0, 32'hCAFE_F00D);
    // Illegal requests: load and store at once, undefined funct3, unsigned store
    txn(1, 1, 3'b010, 32'h0000_0040, 32'h0, 0, 32'h0);
    txn(1, 0, 3'b011, 32'h0000_0040, 32'h0, 0, 32'h0);
    txn(0, 1, 3'b100, 32'h0000_0040, 32'h5A, 0, 32'h0);

    // An ack while idle must be ignored
    txn(1, 0, 3'b001, 32'h0000_0010, 32'h0, 0, 32'h7FFF_8001);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1111_1111;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    check("stray_ack_no_done", done, 1'b0);
    check("stray_ack_load", load_data, exp_ld);

    // Reset in the middle of ACCESS
    mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_0400;
    @(negedge clk);
    mem_read = 1'b0;
    check("pre_rst_re", bus_if.bus_re, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_mid_re", bus_if.bus_re, 1'b0);
    check("rst_mid_stall", stall, 1'b0);
    check("rst_mid_load", load_data, 32'h0);
    exp_ld = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    check("rst_mid_no_done", done, 1'b0);
    check("rst_mid_no_err", err, 1'b0);
    txn(1, 0, 3'b010, 32'h0000_0400, 32'h0, 1, 32'h0BAD_F00D);
    check("post_rst_lw", load_data, 32'h0BAD_F00D);

    // Random transfers
    for (int n = 0; n < 60; n++) begin
      int op = $urandom_range(1, 3);
      txn(op[0], op[1], 3'($urandom_range(0, 7)), $urandom, $urandom,
          $urandom_range(0, TO + 1), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit in case the unit never returns to idle
  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, max ACCESS cycles awaiting bus_ack; 0 disables timeout.
REQ-002 SHALL have ports as listed in REQ-003 to REQ-020; one clock; reset asynchronous, active-high.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 alu_result  input  32  effective address from ALU (rs1+imm).
REQ-006 store_data  input  32  rs2 value for stores.
REQ-007 mem_read  input  1  load instruction present.
REQ-008 mem_write  input  1  store instruction present.
REQ-009 funct3  input  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 stall  output  1  freeze PC/datapath while access pending.
REQ-011 load_data  output  32  aligned, extended load result, valid while done=1.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 err  output  1  one-cycle error pulse, coincident with done.
REQ-014 bus_addr  output  32  word address, {alu_result[31:2],2'b00}.
REQ-015 bus_wdata  output  32  lane-replicated store data.
REQ-016 bus_sel  output  4  byte enables.
REQ-017 bus_re  output  1  read request, held until ack.
REQ-018 bus_we  output  1  write request, held until ack.
REQ-019 bus_rdata  input  32  read data, valid with bus_ack.
REQ-020 bus_ack  input  1  single-cycle transfer acknowledge.

Function
REQ-021 SHALL implement FSM IDLE, ACCESS, DONE.
REQ-022 IDLE: mem_read or mem_write high -> latch address, data, funct3, direction into registers; go ACCESS next cycle.
REQ-023 stall SHALL = (IDLE and (mem_read or mem_write)) or ACCESS; stall=0 in DONE.
REQ-024 ACCESS: bus_re/bus_we asserted from registered values, stable until bus_ack; on ack go DONE.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; min latency request->done = 3 cycles with immediate ack.
REQ-026 bus_sel: B -> 4'b0001<<addr[1:0]; H -> 4'b0011<<{addr[1],1'b0}; W -> 4'b1111.
REQ-027 bus_wdata: B -> {4{data[7:0]}}; H -> {2{data[15:0]}}; W -> data.
REQ-028 Load: rdata >> (8*addr[1:0]), then sign-extend (B,H) or zero-extend (BU,HU), captured on ack.
REQ-029 mem_read and mem_write both high, or funct3 in {011,110,111}, or write with funct3 in {100,101} -> no bus cycle, IDLE->DONE with err=1, load_data=0.
REQ-030 Timeout: counter cleared on ACCESS entry; at TIMEOUT_CYC cycles without ack, drop bus_re/bus_we, go DONE with err=1, load_data=0.
REQ-031 bus_ack outside ACCESS SHALL be ignored.
REQ-032 load_data SHALL hold last value outside DONE; stores leave load_data unchanged.

Reset
REQ-033 rst high SHALL asynchronously force IDLE, counter 0, and all outputs 0 (stall combinationally per REQ-023).
REQ-034 rst mid-ACCESS SHALL drop bus_re/bus_we immediately; no done/err pulse for the aborted access.

Configuration
REQ-035 Macro MISALIGN_TRAP_EN defined: H/HU with addr[0]=1 or W with addr[1:0]!=0 -> no bus cycle, IDLE->DONE, err=1, load_data=0.
REQ-036 MISALIGN_TRAP_EN undefined: no misalignment check; W ignores addr[1:0], H/HU ignore addr[0].

Verification
REQ-037 LW addr 0x100, ack in 1st ACCESS cycle, rdata 0xDEADBEEF -> bus_sel 1111, done at cycle 3, load_data 0xDEADBEEF, err 0.
REQ-038 LB addr 0x103, rdata 0x80112233 -> load_data 0xFFFFFF80; LBU same -> 0x00000080.
REQ-039 SH addr 0x202, store_data 0x0000ABCD -> bus_addr 0x200, bus_sel 1100, bus_wdata 0xABCDABCD, bus_we held until ack.
REQ-040 LW, no ack, TIMEOUT_CYC=4 -> bus_re high 4 cycles, then done=1, err=1, load_data 0.
REQ-041 LW addr 0x101: with MISALIGN_TRAP_EN -> no bus_re, err=1; without -> bus_addr 0x100, normal load.
REQ-042 rst asserted during ACCESS -> bus_re 0 same cycle, no done; post-reset LW completes normally.
